// File: rtl/dvi_symbol_decoder_pkg.sv
// Shared TMDS definitions for the DVI receive path: control tokens, alignment
// states, channel-to-colour mapping and the 10b symbol decode function.
package dvi_symbol_decoder_pkg;

    localparam logic [9:0] TOKEN_C00 = 10'b1101010100;
    localparam logic [9:0] TOKEN_C01 = 10'b0010101011;
    localparam logic [9:0] TOKEN_C10 = 10'b0101010100;
    localparam logic [9:0] TOKEN_C11 = 10'b1010101011;

    localparam int CH_BLUE  = 0;
    localparam int CH_GREEN = 1;
    localparam int CH_RED   = 2;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } align_state_t;

    typedef struct packed {
        logic       de;
        logic [1:0] c;
        logic [7:0] d;
    } tmds_word_t;

    function automatic tmds_word_t tmds_decode(input logic [9:0] sym);
        tmds_word_t w;
        logic [7:0] q;
        w = '0;
        q = sym[9] ? ~sym[7:0] : sym[7:0];
        case (sym)
            TOKEN_C00: w.c = 2'b00;
            TOKEN_C01: w.c = 2'b01;
            TOKEN_C10: w.c = 2'b10;
            TOKEN_C11: w.c = 2'b11;
            default: begin
                w.de   = 1'b1;
                w.d[0] = q[0];
                for (int i = 1; i < 8; i++) begin
                    w.d[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
                end
            end
        endcase
        return w;
    endfunction

endpackage

// File: rtl/dvi_symbol_decoder_tmds_decode.sv
// One TMDS channel: registers the decoded {de, c, d} word for the incoming symbol.
module dvi_symbol_decoder_tmds_decode
    import dvi_symbol_decoder_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] sym,
    output tmds_word_t word
);

    always_ff @(posedge clk) begin
        if (rst) begin
            word <= '0;
        end else begin
            word <= tmds_decode(sym);
        end
    end

endmodule

// File: rtl/dvi_symbol_decoder.sv
// DVI receive decoder: per-channel TMDS decode, deskew on blank-to-active edges,
// lock tracking and the registered video output stage.
module dvi_symbol_decoder
    import dvi_symbol_decoder_pkg::*;
#(
    parameter int MAX_SKEW   = 4,
    parameter int LOCK_LINES = 8,
    parameter int ERR_LIMIT  = 4
) (
    input  logic        PixelClk,
    input  logic        pRst,
    input  logic [9:0]  pDataIn0,
    input  logic [9:0]  pDataIn1,
    input  logic [9:0]  pDataIn2,
    output logic [23:0] vid_pData,
    output logic        vid_pVDE,
    output logic        vid_pHSync,
    output logic        vid_pVSync,
    output logic        pLocked,
    output logic        pAlignErr
);

    localparam int TW = (MAX_SKEW > 2) ? $clog2(MAX_SKEW) : 1;
    localparam int LW = $clog2(LOCK_LINES + 1);
    localparam int EW = $clog2(ERR_LIMIT + 1);
    localparam logic [7:0]    SKEW_LIM  = 8'(MAX_SKEW);
    localparam logic [TW-1:0] WIN_INIT  = TW'(MAX_SKEW - 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_LINES - 1);
    localparam logic [EW-1:0] ERR_LAST  = EW'(ERR_LIMIT - 1);

    logic [9:0]   sym_in [3];
    tmds_word_t   dec    [3];
    tmds_word_t   hist   [3][MAX_SKEW-1];
    tmds_word_t   taps   [3][MAX_SKEW];
    tmds_word_t   al     [3];
    logic [TW-1:0] delay [3];

    logic [2:0] raw_de, raw_prev, raw_edge;
    logic [2:0] al_de, al_prev, al_edge;

    align_state_t  state;
    logic [7:0]    stamp;
    logic [7:0]    ts     [3];
    logic [7:0]    ts_n   [3];
    logic [7:0]    diff   [3];
    logic [7:0]    spread;
    logic [2:0]    got, got_n;
    logic          hunt_dup;
    logic [LW-1:0] line_cnt;
    logic [EW-1:0] err_cnt;
    logic          pend;
    logic [2:0]    seen, seen_n;
    logic [TW-1:0] win;
    logic          good_line, bad_line, start_pend;

    assign sym_in[0] = pDataIn0;
    assign sym_in[1] = pDataIn1;
    assign sym_in[2] = pDataIn2;

    for (genvar g = 0; g < 3; g++) begin : g_ch
        dvi_symbol_decoder_tmds_decode u_dec (
            .clk  (PixelClk),
            .rst  (pRst),
            .sym  (sym_in[g]),
            .word (dec[g])
        );
    end

    always_ff @(posedge PixelClk) begin
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < MAX_SKEW - 1; k++) begin
                if (pRst)       hist[i][k] <= '0;
                else if (k == 0) hist[i][k] <= dec[i];
                else            hist[i][k] <= hist[i][k-1];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            taps[i][0] = dec[i];
            for (int k = 1; k < MAX_SKEW; k++) taps[i][k] = hist[i][k-1];
            al[i]     = taps[i][delay[i]];
            raw_de[i] = dec[i].de;
            al_de[i]  = al[i].de;
        end
        raw_edge = raw_de & ~raw_prev;
        al_edge  = al_de & ~al_prev;
    end

    // HUNT uses the undelayed decoder output so the new taps are absolute,
    // independent of whatever taps were kept from the previous lock.
    always_comb begin
        got_n    = got | raw_edge;
        hunt_dup = |(raw_edge & got);
        spread   = '0;
        for (int i = 0; i < 3; i++) begin
            ts_n[i] = raw_edge[i] ? stamp : ts[i];
            diff[i] = stamp - ts_n[i];
            if (diff[i] > spread) spread = diff[i];
        end
        seen_n     = seen | al_edge;
        good_line  = !pend && (al_edge == 3'b111);
        start_pend = !pend && (al_edge != 3'b000) && (al_edge != 3'b111);
        bad_line   = pend && ((seen_n == 3'b111) || (win == '0));
    end

    always_ff @(posedge PixelClk) begin
        if (pRst) begin
            state      <= HUNT;
            stamp      <= '0;
            got        <= '0;
            line_cnt   <= '0;
            err_cnt    <= '0;
            pend       <= 1'b0;
            seen       <= '0;
            win        <= '0;
            raw_prev   <= '0;
            al_prev    <= '0;
            pLocked    <= 1'b0;
            pAlignErr  <= 1'b0;
            vid_pData  <= '0;
            vid_pVDE   <= 1'b0;
            vid_pHSync <= 1'b0;
            vid_pVSync <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                ts[i]    <= '0;
                delay[i] <= '0;
            end
        end else begin
            stamp     <= stamp + 8'd1;
            raw_prev  <= raw_de;
            al_prev   <= al_de;
            pAlignErr <= 1'b0;

            case (state)
                HUNT: begin
                    if (hunt_dup) begin
                        // restart the measurement from the repeated edge
                        got <= raw_edge;
                        for (int i = 0; i < 3; i++) ts[i] <= stamp;
                    end else if (got_n == 3'b111) begin
                        got <= '0;
                        if (spread < SKEW_LIM) begin
                            for (int i = 0; i < 3; i++) delay[i] <= diff[i][TW-1:0];
                            line_cnt <= '0;
                            err_cnt  <= '0;
                            pend     <= 1'b0;
                            state    <= CHECK;
                        end
                    end else begin
                        got <= got_n;
                        for (int i = 0; i < 3; i++) ts[i] <= ts_n[i];
                    end
                end
                CHECK, LOCKED: begin
                    if (good_line) begin
                        if (state == LOCKED) begin
                            err_cnt <= '0;
                        end else if (line_cnt == LOCK_LAST) begin
                            state   <= LOCKED;
                            pLocked <= 1'b1;
                        end else begin
                            line_cnt <= line_cnt + 1'b1;
                        end
                    end
                    if (bad_line) begin
                        pend      <= 1'b0;
                        pAlignErr <= 1'b1;
                        if (err_cnt == ERR_LAST) begin
                            state   <= HUNT;
                            pLocked <= 1'b0;
                            got     <= '0;
                        end else begin
                            err_cnt <= err_cnt + 1'b1;
                        end
                    end else if (start_pend) begin
                        pend <= 1'b1;
                        seen <= al_edge;
                        win  <= WIN_INIT;
                    end else if (pend) begin
                        seen <= seen_n;
                        win  <= win - 1'b1;
                    end
                end
                default: state <= HUNT;
            endcase

            vid_pVDE  <= (&al_de) && pLocked;
            vid_pData <= (&al_de) ? {al[CH_RED].d, al[CH_BLUE].d, al[CH_GREEN].d} : 24'd0;
            if (!al[CH_BLUE].de) begin
                vid_pVSync <= al[CH_BLUE].c[1];
                vid_pHSync <= al[CH_BLUE].c[0];
            end
        end
    end

endmodule
